riscv_mini_sequencer: RTL and testbench
=======================================

// Module: riscv_mini_sequencer
// PURPOSE
// - Program buffer and issue controller for the RISC-V-mini core.
// - Loads 16-bit instructions byte-serially into a DEPTH-entry buffer, then on run issues one per cycle to the core's instruction input.
// - Supports skip-next on compare result, HALT encoding and external halt.
// - Sits between the pin interface and the core (core is combinational from instruction; regfile clocked).
// PARAMETERS
// - DEPTH   8  number of 16-bit program entries (power of 2)
// - ADDR_W  3  log2(DEPTH); width of pc/wr_ptr
// PORTS
// - clk         in   1       system clock, all state on rising edge
// - rst_n       in   1       asynchronous active-low reset
// - load_valid  in   1       load_byte is valid this cycle
// - load_byte   in   8       program byte; low byte of a word first, then high byte
// - load_ready  out  1       byte accepted when load_valid & load_ready
// - run         in   1       start execution from pc 0 (level sampled each cycle)
// - clr         in   1       discard program, return to IDLE
// - halt_req    in   1       stop execution after the current issue
// - cpu_result  in   8       core result bus (bit 0 = compare outcome)
// - instr_out   out  16      instruction to core
// - instr_valid out  1       instr_out is a real program word
// - pc          out  ADDR_W  index of word on instr_out
// - count       out  ADDR_W+1  words loaded
// - busy        out  1       state == RUN
// - done        out  1       state == DONE
// BEHAVIOUR
// - States: IDLE, RUN, DONE. Reset: IDLE, pc=0, count=0, wr_ptr=0, byte toggle=lo, load_ready=1, instr_valid=0, instr_out=16'h0003, busy=0, done=0. Buffer contents are not reset.
// - NOP = 16'h0003 (opcode 11, funct3 000: no regfile write). instr_out = NOP whenever instr_valid=0.
// - IDLE: load_ready = (count < DEPTH).
//   - Accepted byte with toggle=lo is held as low byte; toggle -> hi.
//   - Accepted byte with toggle=hi writes {byte,low} to mem[wr_ptr]; wr_ptr++, count++, toggle -> lo.
//   - Full (count==DEPTH): load_ready=0; bytes not accepted. Odd dangling low byte is never written.
// - IDLE & run & count!=0 & !clr -> RUN, pc=0. run ignored when count==0.
// - RUN: instr_valid=1, instr_out=mem[pc], load_ready=0 (loads ignored).
//   - Each cycle, pc_next = pc+1, or pc+2 if issued word is compare (opcode 11, funct3 011) and cpu_result[0]==1 (skip-next, sampled same cycle).
//   - HALT word: opcode 11, funct3 110. It is issued (visible for one cycle), then -> DONE.
//   - -> DONE when halt_req, HALT issued, or pc_next >= count (compare in ADDR_W+1 bits; no wrap). pc holds its last value on entry to DONE.
//   - Simultaneous halt_req and HALT word -> single transition to DONE.
// - DONE: done=1, instr_valid=0, load_ready=0.
//   - run & !clr -> RUN with pc=0 (program re-executes).
//   - clr -> IDLE.
// - clr in any state -> IDLE next cycle: count=0, wr_ptr=0, toggle=lo, pc=0. clr wins over run and load_valid.
// - rst_n low mid-operation: immediate return to reset values; instr_out=NOP asynchronously.
// - Latency: word issued the cycle after run is sampled; one word per cycle thereafter.
// TESTING
// - Load bytes 0x21,0x04 / 0x41,0x08 / 0x03,0xE0 (3 words), pulse run -> instr_out 16'h0421,16'h0841,16'hE003 on consecutive cycles, then done=1, instr_out=16'h0003.
// - Load 8 words, then offer a 9th byte -> load_ready=0 after 16th byte, count=8, byte not written; run issues exactly 8 words.
// - Word 0 = compare (16'h6003) with cpu_result=8'h01 -> pc sequence 0,2,3; with 8'h00 -> 0,1,2,3.
// - Word 1 = HALT (16'hC003) in a 4-word program -> words 0,1 issued, DONE; assert halt_req same cycle -> DONE once.
// - Assert rst_n=0 during RUN at pc=2 -> instr_valid=0, pc=0, count=0, load_ready=1 immediately; run after release ignored.
// - In DONE assert run and clr together -> IDLE, count=0; next run ignored until a word is loaded.

Source files
------------

// File: rtl/riscv_mini_sequencer.sv
// riscv_mini_sequencer: byte-serial program buffer and issue controller for the
// RISC-V-mini core. Words are loaded low byte first while idle, then issued one
// per cycle on run, with skip-next on compare, HALT decoding and external halt.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | accepting program bytes, core sees NOP
//   RUN   | issuing mem[pc] each cycle, loads blocked
//   DONE  | program finished or halted, waiting for run or clr
module riscv_mini_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              run,
    input  logic              clr,
    input  logic              halt_req,
    input  logic [7:0]        cpu_result,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0]     NOP        = 16'h0003;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_t            state, state_next;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   count_q;
    logic              toggle;
    logic [7:0]        low_byte;

    logic [15:0]       cur_word;
    logic              is_cmp;
    logic              is_halt;
    logic [ADDR_W:0]   pc_next;
    logic              run_end;
    logic              accept;
    logic              cpu_result_unused;

    // Only the compare flag of the result bus steers sequencing.
    assign cpu_result_unused = ^cpu_result[7:1];

    assign cur_word = mem[pc_q];
    assign is_cmp   = (cur_word[1:0] == 2'b11) && (cur_word[15:13] == 3'b011);
    assign is_halt  = (cur_word[1:0] == 2'b11) && (cur_word[15:13] == 3'b110);
    // Computed one bit wider than pc so a skip past the end cannot wrap to 0.
    assign pc_next  = {1'b0, pc_q} + ((is_cmp && cpu_result[0]) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    assign run_end  = halt_req || is_halt || (pc_next >= count_q);

    assign load_ready  = (state == IDLE) && (count_q < FULL_COUNT);
    assign accept      = load_valid && load_ready && !clr;
    assign instr_valid = (state == RUN);
    assign instr_out   = instr_valid ? cur_word : NOP;
    assign pc          = pc_q;
    assign count       = count_q;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    // Next-state decode; clr overrides every other request.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (run && (count_q != '0)) state_next = RUN;
            RUN:     if (run_end) state_next = DONE;
            DONE:    if (run) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    // State register and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_q  <= '0;
        end else begin
            state <= state_next;
            if (clr || (state != RUN && state_next == RUN))
                pc_q <= '0;
            else if (state == RUN && !run_end)
                pc_q <= pc_next[ADDR_W-1:0];
        end
    end

    // Byte assembly, write pointer and word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            count_q  <= '0;
            toggle   <= 1'b0;
            low_byte <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            count_q <= '0;
            toggle  <= 1'b0;
        end else if (accept) begin
            if (!toggle) begin
                low_byte <= load_byte;
                toggle   <= 1'b1;
            end else begin
                wr_ptr  <= wr_ptr + 1'b1;
                count_q <= count_q + 1'b1;
                toggle  <= 1'b0;
            end
        end
    end

    // Program storage; contents survive reset and clr.
    always_ff @(posedge clk) begin
        if (accept && toggle)
            mem[wr_ptr] <= {load_byte, low_byte};
    end

endmodule

// File: tb/tb_riscv_mini_sequencer.sv
module tb_riscv_mini_sequencer;

    localparam logic [15:0] NOP = 16'h0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        run;
    logic        clr;
    logic        halt_req;
    logic [7:0]  cpu_result;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [2:0]  pc;
    logic [3:0]  count;
    logic        busy;
    logic        done;

    riscv_mini_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .run(run), .clr(clr), .halt_req(halt_req),
        .cpu_result(cpu_result), .instr_out(instr_out), .instr_valid(instr_valid),
        .pc(pc), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] prog [8];
    logic [7:0]  res_seq [16];
    int          halt_at;
    int          got_pc [$];
    logic [15:0] got_w [$];
    int          exp_pc [$];

    typedef struct {
        logic [15:0] w0;
        logic [7:0]  res;
        int          n_exp;
        logic [15:0] pcs_exp;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_byte  = w[7:0];
        tick();
        load_byte  = w[15:8];
        tick();
        load_valid = 1'b0;
    endtask

    // Pulse run, then record every issued (pc, word) until instr_valid drops.
    task automatic run_prog();
        int k;
        got_pc.delete();
        got_w.delete();
        run = 1'b1;
        tick();
        run = 1'b0;
        k = 0;
        while (instr_valid && k < 16) begin
            cpu_result = res_seq[k];
            halt_req   = (k == halt_at);
            got_pc.push_back(int'(pc));
            got_w.push_back(instr_out);
            tick();
            k++;
        end
        cpu_result = 8'h00;
        halt_req   = 1'b0;
        n_checks++;
        if (k >= 16) begin
            n_fail++;
            $display("FAIL run_bound: still issuing after %0d cycles, required end within 16", k);
        end
    endtask

    // Reference: walk the program by the issue rules, listing pcs in order.
    task automatic model_prog(input int n);
        int p;
        int k;
        logic [15:0] w;
        logic op11;
        exp_pc.delete();
        p = 0;
        k = 0;
        while (1) begin
            exp_pc.push_back(p);
            w = prog[p];
            op11 = (w[1:0] == 2'b11);
            if (k == halt_at) break;
            if (op11 && w[15:13] == 3'b110) break;
            p = p + ((op11 && w[15:13] == 3'b011 && res_seq[k][0]) ? 2 : 1);
            k++;
            if (p >= n) break;
        end
    endtask

    task automatic compare_run(input string tag);
        int m;
        check({tag, "_issues"}, got_pc.size(), exp_pc.size());
        m = (got_pc.size() < exp_pc.size()) ? got_pc.size() : exp_pc.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_pc"}, got_pc[i], exp_pc[i]);
            check({tag, "_word"}, got_w[i], prog[exp_pc[i]]);
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_nop"}, instr_out, NOP);
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_byte = 8'h00; run = 1'b0;
        clr = 1'b0; halt_req = 1'b0; cpu_result = 8'h00; halt_at = 99;
        for (int i = 0; i < 16; i++) res_seq[i] = 8'h00;

        vecs[0] = '{16'h6003, 8'h01, 3, 16'h0230};
        vecs[1] = '{16'h6003, 8'h00, 4, 16'h0123};
        vecs[2] = '{16'hC003, 8'h01, 1, 16'h0000};
        vecs[3] = '{16'h0421, 8'h01, 4, 16'h0123};
        vecs[4] = '{16'h6001, 8'h01, 4, 16'h0123};
        vecs[5] = '{16'h6003, 8'hFF, 3, 16'h0230};
        vecs[6] = '{16'h7FFF, 8'h01, 3, 16'h0230};

        #12;
        check("rst_instr_out", instr_out, NOP);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_count", count, 4'd0);
        check("rst_pc", pc, 3'd0);
        check("rst_busy_done", {busy, done}, 2'b00);
        #11 rst_n = 1'b1;
        tick();

        // Basic three-word program loaded byte by byte.
        load_word(16'h0421);
        load_word(16'h0841);
        load_word(16'hE003);
        check("basic_count", count, 4'd3);
        halt_at = 99;
        run_prog();
        check("basic_issues", got_w.size(), 3);
        if (got_w.size() == 3) begin
            check("basic_w0", got_w[0], 16'h0421);
            check("basic_w1", got_w[1], 16'h0841);
            check("basic_w2", got_w[2], 16'hE003);
        end
        check("basic_done", done, 1'b1);
        check("basic_nop", instr_out, NOP);

        // Table: vary word 0 of a four-word program.
        foreach (vecs[v]) begin
            clear_prog();
            load_word(vecs[v].w0);
            load_word(16'h0421);
            load_word(16'h0841);
            load_word(16'hE003);
            for (int i = 0; i < 16; i++) res_seq[i] = vecs[v].res;
            halt_at = 99;
            run_prog();
            check("tbl_issues", got_pc.size(), vecs[v].n_exp);
            for (int i = 0; i < got_pc.size() && i < vecs[v].n_exp; i++)
                check("tbl_pc", got_pc[i], 32'(vecs[v].pcs_exp[15-4*i -: 4]));
            check("tbl_done", done, 1'b1);
        end

        // Full buffer: 8 words, then a 9th byte must be refused.
        clear_prog();
        for (int i = 0; i < 8; i++) begin
            prog[i] = 16'h1000 | 16'(i << 4);
            load_word(prog[i]);
        end
        check("full_count", count, 4'd8);
        check("full_ready", load_ready, 1'b0);
        load_valid = 1'b1; load_byte = 8'hAA;
        tick();
        load_valid = 1'b0;
        check("full_count_after", count, 4'd8);
        for (int i = 0; i < 16; i++) res_seq[i] = 8'h00;
        halt_at = 99;
        model_prog(8);
        run_prog();
        compare_run("full");
        check("full_eight", got_pc.size(), 8);

        // HALT at word 1, with and without halt_req on the same cycle.
        for (int h = 0; h < 2; h++) begin
            clear_prog();
            prog[0] = 16'h0421; prog[1] = 16'hC003; prog[2] = 16'h0841; prog[3] = 16'hE003;
            for (int i = 0; i < 4; i++) load_word(prog[i]);
            halt_at = (h == 1) ? 1 : 99;
            run_prog();
            check("halt_issues", got_pc.size(), 2);
            check("halt_pc_hold", pc, 3'd1);
            tick();
            check("halt_done_stays", {busy, done}, 2'b01);
        end
        halt_at = 99;

        // Reset during RUN at pc 2.
        clear_prog();
        for (int i = 0; i < 4; i++) load_word(16'h0421);
        run = 1'b1; tick(); run = 1'b0;
        tick(); tick();
        check("mid_pc2", pc, 3'd2);
        rst_n = 1'b0;
        #1;
        check("mid_valid", instr_valid, 1'b0);
        check("mid_nop", instr_out, NOP);
        check("mid_pc", pc, 3'd0);
        check("mid_count", count, 4'd0);
        check("mid_ready", load_ready, 1'b1);
        rst_n = 1'b1;
        run = 1'b1; tick(); run = 1'b0;
        check("mid_run_ignored", {busy, instr_valid}, 2'b00);

        // clr and run together in DONE, then run with empty buffer.
        load_word(16'h0421);
        load_word(16'h0841);
        run_prog();
        check("cr_done", done, 1'b1);
        run = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
        check("cr_idle", {busy, done}, 2'b00);
        check("cr_count", count, 4'd0);
        tick();
        check("cr_run_empty", busy, 1'b0);
        run = 1'b0;
        load_word(16'h0A0B);
        run = 1'b1; tick(); run = 1'b0;
        check("cr_run_loaded", busy, 1'b1);
        check("cr_word", instr_out, 16'h0A0B);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_in_run", {busy, done, instr_valid}, 3'b000);
        check("clr_in_run_count", count, 4'd0);

        // Randomized programs against the reference walk.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(1, 8);
            clear_prog();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: prog[i] = {3'b011, 13'($urandom) | 13'h0003};
                    2:    prog[i] = {3'b110, 13'($urandom) | 13'h0003};
                    default: prog[i] = 16'($urandom);
                endcase
                load_word(prog[i]);
            end
            for (int r = 0; r < 1 + ($urandom_range(0, 1)); r++) begin
                for (int i = 0; i < 16; i++) res_seq[i] = 8'($urandom);
                halt_at = $urandom_range(0, 15);
                model_prog(n);
                run_prog();
                compare_run("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
